// File: rtl/sram_bus_bridge.sv
// Clocked bridge from the core's asynchronous SRAM-style bus to a req/ack memory port.
// Strobes are synchronised, each access becomes one memory transaction, and a one-word read cache short-circuits repeat reads.
module sram_bus_bridge #(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 8,
    parameter int MEM_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CACHE_EN    = 1,
    localparam int LANES      = MEM_W / DATA_W,
    localparam int LB         = $clog2(LANES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    SRAM_A,
    inout  wire logic [DATA_W-1:0] SRAM_DQ,
    input  logic                 SRAM_nCE,
    input  logic                 SRAM_nOE,
    input  logic                 SRAM_nWE,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-LB-1:0] mem_addr,
    output logic [LANES-1:0]     mem_be,
    output logic [MEM_W-1:0]     mem_wdata,
    input  logic [MEM_W-1:0]     mem_rdata,
    input  logic                 mem_ack,
    output logic                 busy
);

    // state    | meaning
    // IDLE     | waiting for synced nCE low with nOE or nWE low
    // WR_ISSUE | write latched, raising mem_req
    // RD_ISSUE | read miss latched, raising mem_req
    // WAIT_ACK | mem_req held until mem_ack
    // RD_HIT   | read served from the cached word
    // HOLD     | access done, waiting for the strobes to release
    typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, WAIT_ACK, RD_HIT, HOLD} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] ce_sync, oe_sync, we_sync;
    logic ce_n, oe_n, we_n;
    logic start, hit, release_bus;
    logic [ADDR_W-LB-1:0] word_in;
    logic [LANES-1:0]     be_onehot;

    logic [LB-1:0]        lat_lane;
    logic [DATA_W-1:0]    lat_data;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;
    logic                 cache_valid;
    logic [ADDR_W-LB-1:0] cache_addr;
    logic [MEM_W-1:0]     cache_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_sync <= '1;
            oe_sync <= '1;
            we_sync <= '1;
        end else begin
            ce_sync <= {ce_sync[SYNC_STAGES-2:0], SRAM_nCE};
            oe_sync <= {oe_sync[SYNC_STAGES-2:0], SRAM_nOE};
            we_sync <= {we_sync[SYNC_STAGES-2:0], SRAM_nWE};
        end
    end

    assign ce_n        = ce_sync[SYNC_STAGES-1];
    assign oe_n        = oe_sync[SYNC_STAGES-1];
    assign we_n        = we_sync[SYNC_STAGES-1];
    assign start       = ~ce_n & (~oe_n | ~we_n);
    assign release_bus = ce_n | (oe_n & we_n);
    assign word_in     = SRAM_A[ADDR_W-1:LB];
    assign be_onehot   = LANES'(1) << SRAM_A[LB-1:0];
    assign hit         = (CACHE_EN != 0) && cache_valid && (cache_addr == word_in);
    assign busy        = (state != IDLE);

    // Pin-level gating so the bus turns around as soon as the core lets go.
    assign SRAM_DQ = (~SRAM_nCE & ~SRAM_nOE & SRAM_nWE & rd_valid) ? rd_data : 'z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (~we_n)    state_nxt = WR_ISSUE;
                    else if (hit) state_nxt = RD_HIT;
                    else          state_nxt = RD_ISSUE;
                end
            end
            WR_ISSUE, RD_ISSUE: state_nxt = WAIT_ACK;
            WAIT_ACK:           if (mem_ack) state_nxt = HOLD;
            RD_HIT:             state_nxt = HOLD;
            HOLD:               if (release_bus) state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            lat_lane    <= '0;
            lat_data    <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_word  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        lat_lane <= SRAM_A[LB-1:0];
                        lat_data <= SRAM_DQ;
                        if (~we_n || !hit) begin
                            mem_we   <= ~we_n;
                            mem_addr <= word_in;
                            mem_be   <= ~we_n ? be_onehot : '1;
                            if (~we_n) mem_wdata <= {LANES{SRAM_DQ}};
                        end
                    end
                end
                WR_ISSUE, RD_ISSUE: mem_req <= 1'b1;
                WAIT_ACK: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            if (cache_valid && cache_addr == mem_addr)
                                cache_word[int'(lat_lane)*DATA_W +: DATA_W] <= lat_data;
                        end else begin
                            if (CACHE_EN != 0) begin
                                cache_word  <= mem_rdata;
                                cache_addr  <= mem_addr;
                                cache_valid <= 1'b1;
                            end
                            rd_data  <= mem_rdata[int'(lat_lane)*DATA_W +: DATA_W];
                            // A core that already walked away gets its data cached, not driven.
                            rd_valid <= ~ce_n & ~oe_n;
                        end
                    end
                end
                RD_HIT: begin
                    rd_data  <= cache_word[int'(lat_lane)*DATA_W +: DATA_W];
                    rd_valid <= 1'b1;
                end
                HOLD: if (release_bus) rd_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Scoreboard bench for sram_bus_bridge: stimulus queues expected memory requests and read bytes,
// a negedge monitor pops them when the bridge raises mem_req or drives the data bus.
module tb_sram_bus_bridge;

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } mem_t;

    typedef struct {
        logic [7:0] data;
        bit         from_ack;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [20:0] sram_a = '0;
    tri1  [7:0]  sram_dq;
    logic        sram_nce = 1'b1, sram_noe = 1'b1, sram_nwe = 1'b1;
    logic        mem_req, mem_we, busy;
    logic [19:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic [7:0]  tb_dq = '0;
    logic        tb_dq_oe = 1'b0;
    assign sram_dq = tb_dq_oe ? tb_dq : 8'hzz;

    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, strobe_cnt = 0, ack_cnt = 0;
    int   ack_delay = 3, ack_wait = -1;
    bit   hold_ack = 0, just_acked = 0, req_prev = 0, rd_seen = 0;
    logic [15:0] resp_data = '0;
    mem_t exp_mem[$];
    rd_t  exp_rd[$];

    sram_bus_bridge dut (
        .clk(clk), .reset(reset), .SRAM_A(sram_a), .SRAM_DQ(sram_dq),
        .SRAM_nCE(sram_nce), .SRAM_nOE(sram_noe), .SRAM_nWE(sram_nwe),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder plus scoreboard monitor, all sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        mem_ack = 1'b0;
        if (reset) begin
            ack_wait   = -1;
            just_acked = 0;
        end else begin
            if (just_acked) begin
                chk("req_drop_after_ack", mem_req, 0);
                just_acked = 0;
            end
            if (ack_wait > 0) begin
                chk("req_held", mem_req, 1);
                if (!hold_ack) ack_wait--;
            end else if (ack_wait == 0) begin
                chk("req_held", mem_req, 1);
                mem_ack    = 1'b1;
                mem_rdata  = resp_data;
                ack_cnt    = cyc;
                ack_wait   = -1;
                just_acked = 1;
            end else if (mem_req && !req_prev) begin
                ack_wait = ack_delay - 1;
            end
        end

        if (mem_req && !req_prev) begin
            if (exp_mem.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_req: mem_req with addr 0x%0h, expected none", mem_addr);
            end else begin
                mem_t e;
                e = exp_mem.pop_front();
                chk("mem_we", mem_we, e.we);
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_be", mem_be, e.be);
                if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                chk("req_latency", cyc - strobe_cnt, 4);
            end
        end

        if (!tb_dq_oe && sram_dq !== 8'hFF && !rd_seen) begin
            rd_seen = 1;
            if (exp_rd.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_drive: SRAM_DQ=0x%0h, expected Z", sram_dq);
            end else begin
                rd_t r;
                r = exp_rd.pop_front();
                chk("rd_data", sram_dq, r.data);
                chk("rd_latency", r.from_ack ? cyc - ack_cnt : cyc - strobe_cnt, r.from_ack ? 1 : 4);
            end
        end
        if (sram_nce || sram_noe) rd_seen = 0;
        req_prev = mem_req;
    end

    task automatic start_acc(input logic [20:0] a, input bit rd, input bit wr, input logic [7:0] d);
        @(negedge clk);
        sram_a     = a;
        tb_dq      = d;
        tb_dq_oe   = wr;
        sram_nce   = 1'b0;
        sram_noe   = !rd;
        sram_nwe   = !wr;
        strobe_cnt = cyc;
    endtask

    task automatic end_acc();
        @(negedge clk);
        sram_nce = 1'b1;
        sram_noe = 1'b1;
        sram_nwe = 1'b1;
        tb_dq_oe = 1'b0;
    endtask

    task automatic wait_mem_done(input string nm);
        for (int i = 0; i < 60 && exp_mem.size() != 0; i++) @(negedge clk);
        chk({"mem_pending_", nm}, exp_mem.size(), 0);
    endtask

    task automatic wait_rd_done(input string nm);
        for (int i = 0; i < 60 && exp_rd.size() != 0; i++) @(negedge clk);
        chk({"rd_pending_", nm}, exp_rd.size(), 0);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk);
        chk({"busy_clear_", nm}, busy, 0);
    endtask

    task automatic do_write(input string nm, input logic [20:0] a, input logic [7:0] d, input logic [1:0] be);
        mem_t m;
        m = '{we: 1'b1, addr: 20'(a >> 1), be: be, wdata: {d, d}};
        ack_delay = 2;
        exp_mem.push_back(m);
        start_acc(a, 0, 1, d);
        wait_mem_done(nm);
        repeat (6) @(negedge clk);
        chk({"busy_", nm}, busy, 1);
        end_acc();
        wait_idle(nm);
    endtask

    task automatic do_read_miss(input string nm, input logic [20:0] a, input logic [15:0] resp,
                                input int dly, input logic [7:0] exp_b);
        mem_t m;
        rd_t  r;
        m = '{we: 1'b0, addr: 20'(a >> 1), be: 2'b11, wdata: 16'h0};
        r = '{data: exp_b, from_ack: 1'b1};
        resp_data = resp;
        ack_delay = dly;
        exp_mem.push_back(m);
        exp_rd.push_back(r);
        start_acc(a, 1, 0, 8'h00);
        wait_rd_done(nm);
        @(negedge clk);
        end_acc();
        wait_idle(nm);
    endtask

    task automatic do_read_hit(input string nm, input logic [20:0] a, input logic [7:0] exp_b);
        rd_t r;
        r = '{data: exp_b, from_ack: 1'b0};
        exp_rd.push_back(r);
        start_acc(a, 1, 0, 8'h00);
        wait_rd_done(nm);
        @(negedge clk);
        end_acc();
        wait_idle(nm);
    endtask

    initial begin
        mem_t m;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dq_z", sram_dq, 8'hFF);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single write, upper lane of word 1
        do_write("wr_a5", 21'h00003, 8'hA5, 2'b10);

        // miss then hit in the same word
        do_read_miss("rd_miss_2", 21'h00002, 16'h1234, 3, 8'h34);
        do_read_hit("rd_hit_3", 21'h00003, 8'h12);

        // write-through into the cached word
        do_read_miss("rd_miss_10", 21'h00010, 16'h5566, 2, 8'h66);
        do_write("wr_77", 21'h00011, 8'h77, 2'b10);
        do_read_hit("rd_hit_11", 21'h00011, 8'h77);

        // nOE and nWE together: write only, bus never driven
        m = '{we: 1'b1, addr: 20'h00010, be: 2'b01, wdata: 16'h3C3C};
        ack_delay = 2;
        exp_mem.push_back(m);
        start_acc(21'h00020, 1, 1, 8'h3C);
        wait_mem_done("both_low");
        repeat (4) @(negedge clk);
        tb_dq_oe = 1'b0;
        @(negedge clk);
        chk("both_low_no_drive", sram_dq, 8'hFF);
        sram_nwe = 1'b1;
        repeat (4) @(negedge clk);
        chk("both_low_no_drive_oe_only", sram_dq, 8'hFF);
        chk("both_low_hold", busy, 1);
        end_acc();
        wait_idle("both_low");

        // core abandons a read miss before mem_ack: cache still fills
        m = '{we: 1'b0, addr: 20'h00020, be: 2'b11, wdata: 16'h0};
        resp_data = 16'h9A4B;
        ack_delay = 8;
        exp_mem.push_back(m);
        start_acc(21'h00040, 1, 0, 8'h00);
        wait_mem_done("abandon");
        end_acc();
        wait_idle("abandon");
        chk("abandon_no_drive", sram_dq, 8'hFF);
        do_read_hit("rd_hit_41", 21'h00041, 8'h9A);

        // reset while waiting for mem_ack
        hold_ack  = 1;
        ack_delay = 2;
        m = '{we: 1'b0, addr: 20'h00030, be: 2'b11, wdata: 16'h0};
        exp_mem.push_back(m);
        start_acc(21'h00060, 1, 0, 8'h00);
        wait_mem_done("pre_reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dq_z", sram_dq, 8'hFF);
        @(negedge clk);
        sram_nce = 1'b1;
        sram_noe = 1'b1;
        sram_nwe = 1'b1;
        reset    = 1'b0;
        hold_ack = 0;
        repeat (3) @(negedge clk);
        do_read_miss("rd_after_rst", 21'h00041, 16'hBEEF, 2, 8'hBE);

        repeat (4) @(negedge clk);
        chk("end_mem_queue", exp_mem.size(), 0);
        chk("end_rd_queue", exp_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
